// File: rtl/mu_avmm_burst_responder.sv
// mu_avmm_burst_responder
// Avalon-MM burst slave backed by a single-port on-chip RAM. It stands in for a
// local-memory bank behind the DMA master port, or serves as an on-chip
// scratchpad. One beat moves per cycle; bursts are up to MAX_BURST beats long.
//
// Ports
//   primary_clk        sole clock
//   reset              synchronous, active-high
//   avs_waitrequest    stall; a command or beat is taken when valid & !waitrequest
//   avs_readdata       read beat data
//   avs_readdatavalid  avs_readdata valid this cycle
//   avs_burstcount     beats in burst (sampled on the first beat only)
//   avs_writedata      write beat data
//   avs_address        word address (sampled on the first beat only)
//   avs_write          write beat request
//   avs_read           read burst request
//   avs_byteenable     per-byte write enable (ignored on reads)
//   err_clear          clears err
//   err                sticky protocol-error flag
//
// Build option: MU_AVMM_RESP_BACKPRESSURE_EN inserts pseudo-random stalls
// (about 25%) in IDLE and WR_BURST, driven by a 16-bit LFSR.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command; first beat of any burst handled here
// WR_BURST | taking write beats 2..bc; avs_write=0 cycles are bubbles
// RD_BURST | issuing read beats 2..bc, one per cycle, master stalled

module mu_avmm_burst_responder #(
   parameter int DATA_WIDTH  = 512,
   parameter int ADDR_WIDTH  = 10,
   parameter int BURST_WIDTH = 3,
   parameter int MAX_BURST   = 4
) (
   input  logic                    primary_clk,
   input  logic                    reset,
   output logic                    avs_waitrequest,
   output logic [DATA_WIDTH-1:0]   avs_readdata,
   output logic                    avs_readdatavalid,
   input  logic [BURST_WIDTH-1:0]  avs_burstcount,
   input  logic [DATA_WIDTH-1:0]   avs_writedata,
   input  logic [ADDR_WIDTH-1:0]   avs_address,
   input  logic                    avs_write,
   input  logic                    avs_read,
   input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
   input  logic                    err_clear,
   output logic                    err
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int DEPTH  = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic [BURST_WIDTH-1:0]  rem_q, rem_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    rvalid_q;
   logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];

   logic                    wr_en, rd_en, err_set, stall;
   logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
   logic                    bc_bad;
   logic [BURST_WIDTH-1:0]  bc_eff;

   // Out-of-range burstcounts degrade to a single beat and flag an error.
   assign bc_bad = (avs_burstcount == '0) ||
                   (avs_burstcount > BURST_WIDTH'(MAX_BURST));
   assign bc_eff = bc_bad ? BURST_WIDTH'(1) : avs_burstcount;

`ifdef MU_AVMM_RESP_BACKPRESSURE_EN
   logic [15:0] lfsr_q;

   // Fibonacci LFSR, taps 16,14,13,11.
   always_ff @(posedge primary_clk) begin
      if (reset) lfsr_q <= 16'hACE1;
      else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // State register
   always_ff @(posedge primary_clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         rem_q    <= '0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         rem_q    <= rem_d;
         err_q    <= err_d;
         rvalid_q <= rd_en;
         if (rd_en) rdata_q <= mem_q[rd_addr];
      end
   end

   // RAM array is never reset; contents survive reset.
   always_ff @(posedge primary_clk) begin
      if (wr_en) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (avs_byteenable[b]) mem_q[wr_addr][b*8 +: 8] <= avs_writedata[b*8 +: 8];
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      wr_en   = 1'b0;
      wr_addr = ptr_q;
      rd_en   = 1'b0;
      rd_addr = ptr_q;
      err_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!avs_waitrequest) begin
               if (avs_write) begin
                  // A simultaneous read is dropped; write wins.
                  wr_en   = 1'b1;
                  wr_addr = avs_address;
                  err_set = bc_bad | avs_read;
                  if (bc_eff > BURST_WIDTH'(1)) begin
                     state_d = WR_BURST;
                     ptr_d   = avs_address + ADDR_WIDTH'(1);
                     rem_d   = bc_eff - BURST_WIDTH'(1);
                  end
               end else if (avs_read) begin
                  rd_en   = 1'b1;
                  rd_addr = avs_address;
                  err_set = bc_bad;
                  if (bc_eff > BURST_WIDTH'(1)) begin
                     state_d = RD_BURST;
                     ptr_d   = avs_address + ADDR_WIDTH'(1);
                     rem_d   = bc_eff - BURST_WIDTH'(1);
                  end
               end
            end
         end
         WR_BURST: begin
            if (!avs_waitrequest && avs_write) begin
               wr_en = 1'b1;
               ptr_d = ptr_q + ADDR_WIDTH'(1);
               rem_d = rem_q - BURST_WIDTH'(1);
               if (rem_q == BURST_WIDTH'(1)) state_d = IDLE;
            end
         end
         RD_BURST: begin
            rd_en = 1'b1;
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            rem_d = rem_q - BURST_WIDTH'(1);
            if (rem_q == BURST_WIDTH'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Clear beats a same-cycle error.
      err_d = err_clear ? 1'b0 : (err_q | err_set);
   end

   // Outputs
   always_comb begin
      avs_waitrequest = (state_q == RD_BURST) || stall;
   end

   assign avs_readdata      = rdata_q;
   assign avs_readdatavalid = rvalid_q;
   assign err               = err_q;

endmodule
